// File: rtl/mem_pkg.sv
// Shared types and helpers for mem_unit: FSM states, wait-state limit and even parity.
package mem_pkg;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W           = 4;
  localparam int PAR_MAX_W       = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even parity over the low 'width' bits of a zero-extended word.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data, input int width);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Request/response bus between a requester and mem_unit.
// par_err / par_inject exist only when MEM_PARITY_EN is defined.
interface mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] BusMuxOut;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_ready;
  logic              busy;
  logic              addr_err;
`ifdef MEM_PARITY_EN
  logic              par_err;
  logic              par_inject;

  modport master (
    output read, write, address, BusMuxOut, par_inject,
    input  Mdatain, mem_ready, busy, addr_err, par_err
  );

  modport slave (
    input  read, write, address, BusMuxOut, par_inject,
    output Mdatain, mem_ready, busy, addr_err, par_err
  );
`else
  modport master (
    output read, write, address, BusMuxOut,
    input  Mdatain, mem_ready, busy, addr_err
  );

  modport slave (
    input  read, write, address, BusMuxOut,
    output Mdatain, mem_ready, busy, addr_err
  );
`endif
endinterface

// File: rtl/mem_array.sv
// Word storage for mem_unit: synchronous write port, registered read port.
// With MEM_PARITY_EN each word carries an even-parity bit and reads flag mismatches.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              wpar_inv,
  output logic              rpar_err,
`endif
  output logic [DATA_W-1:0] rdata
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wword;

`ifdef MEM_PARITY_EN
  assign wword = {even_parity(PAR_MAX_W'(wdata), DATA_W) ^ wpar_inv, wdata};
`else
  assign wword = wdata;
`endif

  // NOTE: the storage array has no reset; its contents survive clear_n and a
  // resettable array would stop the tools from mapping it onto RAM macros.
  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= wword;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rdata    <= '0;
`ifdef MEM_PARITY_EN
      rpar_err <= 1'b0;
`endif
    end else begin
`ifdef MEM_PARITY_EN
      rpar_err <= 1'b0;
`endif
      if (rd_en) begin
        rdata <= mem[idx][DATA_W-1:0];
`ifdef MEM_PARITY_EN
        rpar_err <= (even_parity(PAR_MAX_W'(mem[idx][DATA_W-1:0]), DATA_W) != mem[idx][DATA_W]);
`endif
      end else if (rd_clr) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: clocked RAM with programmable wait states, one-cycle ready pulse and range check.
// Define MEM_PARITY_EN to add per-word even parity with par_err / par_inject.
module mem_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input logic  clock,
  input logic  clear_n,
  mem_if.slave bus
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Settings beyond the counter's reach saturate instead of wrapping.
  localparam int WAIT_N = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              mem_ready_q;
  logic              addr_err_q;

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              rd_clr;
  logic [DATA_W-1:0] rdata;

`ifdef MEM_PARITY_EN
  logic inject_q;
  logic acc_inject;
  logic rpar_err;
`endif

  // With zero wait states the access uses the live request at the accept edge;
  // otherwise it uses the request latched at accept.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    accept    = (state == IDLE) && (bus.read || bus.write);
    access    = (state == WAIT) && (cnt == '0);
    acc_write = op_write;
    acc_addr  = addr_q;
    acc_data  = data_q;
`ifdef MEM_PARITY_EN
    acc_inject = inject_q;
`endif
    if ((WAIT_N == 0) && accept) begin
      access    = 1'b1;
      acc_write = bus.write;
      acc_addr  = bus.address;
      acc_data  = bus.BusMuxOut;
`ifdef MEM_PARITY_EN
      acc_inject = bus.par_inject;
`endif
    end
  end

  assign in_range = 32'(acc_addr) < 32'(DEPTH);
  assign wr_en    = access && acc_write && in_range;
  assign rd_en    = access && !acc_write && in_range;
  assign rd_clr   = access && !acc_write && !in_range;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      mem_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef MEM_PARITY_EN
      inject_q    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      mem_ready_q <= access;
      addr_err_q  <= access && !in_range;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write <= bus.write;
            addr_q   <= bus.address;
            data_q   <= bus.BusMuxOut;
`ifdef MEM_PARITY_EN
            inject_q <= bus.par_inject;
`endif
            busy_q   <= 1'b1;
            if (WAIT_N == 0) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_N - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock    (clock),
    .clear_n  (clear_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_clr   (rd_clr),
    .idx      (acc_addr[IDX_W-1:0]),
    .wdata    (acc_data),
`ifdef MEM_PARITY_EN
    .wpar_inv (acc_inject),
    .rpar_err (rpar_err),
`endif
    .rdata    (rdata)
  );

  assign bus.Mdatain   = rdata;
  assign bus.mem_ready = mem_ready_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = addr_err_q;
`ifdef MEM_PARITY_EN
  assign bus.par_err   = rpar_err;
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: three instances (1 wait/512 words, 0 waits, 2 waits/256 words).
// Parity checks are compiled in when MEM_PARITY_EN is defined.
module tb_mem_unit;

  typedef struct {
    bit          is_wr;
    bit          aerr;
    bit          perr;
    bit          known;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [8:0]  addr_s [3];
  logic [31:0] data_s [3];
  logic        rdy    [3];
  logic        bsy    [3];
  logic        aerr   [3];
  logic [31:0] mdat   [3];
`ifdef MEM_PARITY_EN
  logic        inj_s  [3];
  logic        perr   [3];
`endif

  int wc_of    [3] = '{1, 0, 2};
  int depth_of [3] = '{512, 512, 256};

  logic [31:0] model_mem [3][512];
  bit          model_vld [3][512];
  bit          model_par [3][512];
  logic [31:0] last_rd    [3];
  bit          last_known [3];
  exp_t        sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cnt [3] = '{0, 0, 0};

  mem_if #(.DATA_W(32), .ADDR_W(9)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].read      = rd_s[g];
    assign bus[g].write     = wr_s[g];
    assign bus[g].address   = addr_s[g];
    assign bus[g].BusMuxOut = data_s[g];
    assign rdy[g]           = bus[g].mem_ready;
    assign bsy[g]           = bus[g].busy;
    assign aerr[g]          = bus[g].addr_err;
    assign mdat[g]          = bus[g].Mdatain;
`ifdef MEM_PARITY_EN
    assign bus[g].par_inject = inj_s[g];
    assign perr[g]           = bus[g].par_err;
`endif
  end

  mem_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) u_w1 (
    .clock(clk), .clear_n(rst_n), .bus(bus[0]));
  mem_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) u_w0 (
    .clock(clk), .clear_n(rst_n), .bus(bus[1]));
  mem_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2)) u_d256 (
    .clock(clk), .clear_n(rst_n), .bus(bus[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) ready_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // One complete request on instance d; starts and ends at a falling edge.
  task automatic access(input int d, input bit w, input bit r, input logic [8:0] a,
                        input logic [31:0] dat, input bit inj);
    exp_t e;
    int   k;
    e.is_wr = w;
    e.lat   = wc_of[d];
    e.aerr  = (32'(a) >= depth_of[d]);
    e.perr  = 1'b0;
    if (w) begin
      if (!e.aerr) begin
        model_mem[d][a] = dat;
        model_vld[d][a] = 1'b1;
        model_par[d][a] = inj;
      end
      e.known = last_known[d];
      e.data  = last_rd[d];
    end else if (e.aerr) begin
      e.known = 1'b1;
      e.data  = '0;
    end else begin
      e.known = model_vld[d][a];
      e.data  = model_mem[d][a];
      e.perr  = model_par[d][a];
    end
    sb_q.push_back(e);

    wr_s[d]   = w;
    rd_s[d]   = r;
    addr_s[d] = a;
    data_s[d] = dat;
`ifdef MEM_PARITY_EN
    inj_s[d]  = inj;
`endif
    @(posedge clk);
    @(negedge clk);
    wr_s[d] = 1'b0;
    rd_s[d] = 1'b0;
`ifdef MEM_PARITY_EN
    inj_s[d] = 1'b0;
`endif
    check("busy_after_accept", bsy[d], 1);
    k = 0;
    while (rdy[d] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    check("ready_latency", k, e.lat);
    check("addr_err", aerr[d], e.aerr);
    if (e.known) check(e.is_wr ? "mdatain_hold" : "read_data", mdat[d], e.data);
`ifdef MEM_PARITY_EN
    check("par_err", perr[d], e.perr);
`endif
    if (!w) begin
      last_known[d] = e.known;
      last_rd[d]    = e.data;
    end
    @(negedge clk);
    check("ready_pulse_end", rdy[d], 0);
    check("busy_release", bsy[d], 0);
    check("addr_err_pulse_end", aerr[d], 0);
  endtask

  initial begin
    int          cnt0;
    int          k;
    int          d;
    bit          w;
    logic [8:0]  a;
    logic [31:0] dat;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; data_s[i] = '0;
`ifdef MEM_PARITY_EN
      inj_s[i] = 1'b0;
`endif
      last_rd[i] = '0; last_known[i] = 1'b1;
      for (int j = 0; j < 512; j++) begin
        model_vld[i][j] = 1'b0; model_par[i][j] = 1'b0; model_mem[i][j] = '0;
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", bsy[i], 0);
      check("reset_ready", rdy[i], 0);
      check("reset_addr_err", aerr[i], 0);
      check("reset_mdatain", mdat[i], 0);
    end

    // Reset in the middle of a write's wait state discards the write.
    wr_s[0] = 1'b1; addr_s[0] = 9'h010; data_s[0] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    wr_s[0] = 1'b0;
    check("busy_in_wait", bsy[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bsy[0], 0);
    check("midrst_ready", rdy[0], 0);
    check("midrst_addr_err", aerr[0], 0);
    check("midrst_mdatain", mdat[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = '0; last_known[i] = 1'b1;
    end
    @(negedge clk);
    access(0, 1'b0, 1'b1, 9'h010, 32'h0, 1'b0);
    check("midrst_write_discarded", mdat[0] == 32'hDEADBEEF, 0);

    // One wait state: write/read top address, data holds through a later write.
    access(0, 1'b1, 1'b0, 9'h1FF, 32'h12345678, 1'b0);
    access(0, 1'b0, 1'b1, 9'h1FF, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 9'h000, 32'h0F0F0F0F, 1'b0);
    check("hold_after_write", mdat[0], 32'h12345678);

    // Zero wait states: write dominates read.
    access(1, 1'b1, 1'b1, 9'h005, 32'hA5A5A5A5, 1'b0);
    access(1, 1'b0, 1'b1, 9'h005, 32'h0, 1'b0);

    // 256-word instance: out-of-range read/write must not alias onto word 0.
    access(2, 1'b1, 1'b0, 9'h000, 32'hCAFE0000, 1'b0);
    access(2, 1'b0, 1'b1, 9'h000, 32'h0, 1'b0);
    access(2, 1'b0, 1'b1, 9'h100, 32'h0, 1'b0);
    access(2, 1'b1, 1'b0, 9'h100, 32'hFFFFFFFF, 1'b0);
    access(2, 1'b0, 1'b1, 9'h000, 32'h0, 1'b0);
    access(2, 1'b0, 1'b1, 9'h0FF, 32'h0, 1'b0);

    // Strobe held through DONE: exactly one access.
    access(0, 1'b1, 1'b0, 9'h020, 32'h0BADF00D, 1'b0);
    cnt0 = ready_cnt[0];
    wr_s[0] = 1'b1; addr_s[0] = 9'h030; data_s[0] = 32'h11111111;
    model_mem[0][9'h030] = 32'h11111111; model_vld[0][9'h030] = 1'b1; model_par[0][9'h030] = 1'b0;
    @(negedge clk);
    k = 0;
    while (rdy[0] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("held_latency", k, 1);
    @(negedge clk);
    check("held_done_ignored", bsy[0], 0);
    wr_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("held_single_access", ready_cnt[0] - cnt0, 1);

    // Strobe re-asserted in WAIT with a new target: not queued.
    cnt0 = ready_cnt[0];
    wr_s[0] = 1'b1; addr_s[0] = 9'h040; data_s[0] = 32'h22222222;
    model_mem[0][9'h040] = 32'h22222222; model_vld[0][9'h040] = 1'b1; model_par[0][9'h040] = 1'b0;
    @(negedge clk);
    addr_s[0] = 9'h020; data_s[0] = 32'h33333333;
    @(negedge clk);
    check("wait_strobe_ready", rdy[0], 1);
    wr_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_no_queue", ready_cnt[0] - cnt0, 1);
    check("wait_idle", bsy[0], 0);
    access(0, 1'b0, 1'b1, 9'h040, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 9'h020, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 9'h030, 32'h0, 1'b0);

`ifdef MEM_PARITY_EN
    access(0, 1'b1, 1'b0, 9'h050, 32'h00000001, 1'b1);
    access(0, 1'b0, 1'b1, 9'h050, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 9'h050, 32'h00000001, 1'b0);
    access(0, 1'b0, 1'b1, 9'h050, 32'h0, 1'b0);
`endif

    // Mixed random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      d   = int'($urandom_range(0, 2));
      w   = 1'(($urandom_range(0, 1)));
      a   = 9'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a + 9'h100;
      dat = $urandom;
      access(d, w, w ? 1'($urandom_range(0, 1)) : 1'b1, a, dat, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
